histogram_count_pipeline: RTL and testbench
===========================================

# histogram_count_pipeline

Parametrised first stage of the histogram equalizer. Streams every pixel of the source image from memory m1 and builds a per-intensity occurrence count in scratchpad memory m2, one pixel per cycle, with full read-after-write forwarding. The scratchpad is cleared in-block before counting. It sits between the input image memory (m1) and the CDF stage, which starts on `done`.

## Interface
- `PIXEL_W`, 8: bits per pixel; the scratchpad holds 2^PIXEL_W bins.
- `PIX_PER_WORD`, 16: pixels per m1 word; lane 0 is bits [PIXEL_W-1:0].
- `NUM_WORDS`, 4: image length in m1 words, addresses 0..NUM_WORDS-1, NUM_WORDS ≥ 1.
- `BIN_W`, 16: bin count width.
- `ADDR_W`, 16: m1 address width.

Ports:
- `clock` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request; sampled only in IDLE or DONE.
- `m1ReadVal` in PIX_PER_WORD*PIXEL_W: m1 data, valid 1 cycle after address.
- `m2ReadVal` in BIN_W: m2 data, valid 1 cycle after address.
- `m1ReadAddr` out ADDR_W: m1 word address.
- `m2ReadAddr` out PIXEL_W: bin read address.
- `m2WriteAddr` out PIXEL_W: bin write address.
- `m2WriteVal` out BIN_W: bin write data.
- `m2WE` out 1: m2 write strobe.
- `busy` out 1: high in CLEAR, COUNT and DRAIN.
- `done` out 1: level; high in DONE until the next accepted `start`.

## Operation
- FSM states: IDLE, CLEAR, COUNT, DRAIN, DONE.
- IDLE or DONE + `start` → CLEAR; clear `done`, reset the bin and word counters.
- CLEAR: write 0 to bins 0..2^PIXEL_W-1, one per cycle (`m2WE`=1). In parallel, issue m1 read of word 0 on the last clear cycle. Then → COUNT.
- COUNT: one pixel per cycle, lanes 0..PIX_PER_WORD-1 of each word in order. On lane PIX_PER_WORD-1 of word w, issue the read of word w+1 (if w+1<NUM_WORDS) so there are no bubbles. After the final lane of word NUM_WORDS-1 → DRAIN.
- Pixel pipeline:
  - F: `m2ReadAddr` ← pixel.
  - R: select the count source, highest priority first: the A-stage result if A.bin==R.bin; else the W-stage data if W.bin==R.bin and W is valid; else `m2ReadVal`.
  - A: count+1.
  - W: `m2WriteAddr`/`m2WriteVal`/`m2WE`.
- Every valid pixel produces exactly one write. The last write for a bin is always its final count.
- Arithmetic: increment is modulo 2^BIN_W (wraps), unless saturation is enabled (see Configuration).
- DRAIN: wait until the pipeline is empty (3 cycles) → DONE.
- `start` in CLEAR/COUNT/DRAIN is ignored.
- Reset at any time: asynchronous return to IDLE. All pipeline valids are cleared, so no further writes occur. Scratchpad contents are undefined; a new `start` is required.

## Timing
- Reset values: `m1ReadAddr`=0, `m2ReadAddr`=0, `m2WriteAddr`=0, `m2WriteVal`=0, `m2WE`=0, `busy`=0, `done`=0.
- `start` accepted at edge t → first clear write visible in cycle t+1. CLEAR lasts 2^PIXEL_W cycles.
- First pixel write occurs 3 cycles after COUNT entry.
- Total from `start` to `done`=1: 1 + 2^PIXEL_W + NUM_WORDS*PIX_PER_WORD + 3 cycles. Defaults give 1+256+64+3 = 324.
- `m2WE` is never high in IDLE or DONE.
- Back-to-back same-bin pixels sustain 1 pixel/cycle via forwarding; there are no stalls.

## Configuration
- `HIST_SATURATE_EN` defined: the A stage clamps at 2^BIN_W-1, so further hits leave that value.
- `HIST_SATURATE_EN` undefined: the count wraps to 0 after 2^BIN_W-1.

## Test plan
- Ramp image, defaults (pixels 0..63) → bins 0..63 = 1, all others 0; `done` at cycle 324 after `start`.
- All 64 pixels = 0x5A → final write to bin 0x5A = 64 with no lost increments. Exactly 64 count writes plus 256 clear writes.
- Alternating pattern 0x10,0x20,0x10,… → bin 0x10 = 32, bin 0x20 = 32 (exercises W-stage forwarding).
- BIN_W=4, 20 pixels of 0x03 → bin 3 = 4 without the macro (wrap), = 15 with `HIST_SATURATE_EN`.
- Deassert `rst_n` mid-COUNT → outputs take their reset values immediately and `m2WE` stays 0. A new `start` gives correct counts from scratch.
- Pulse `start` during COUNT → no effect, identical counts and `done` timing; `start` in DONE → `done` drops and CLEAR restarts.

Source files
------------

// File: rtl/histogram_count_pipeline.sv
// Histogram count stage: clears the 2^PIXEL_W-bin scratchpad, then counts every m1 pixel
// at one pixel per cycle with read-after-write forwarding. Define HIST_SATURATE_EN to clamp bins.
module histogram_count_pipeline #(
    parameter int PIXEL_W      = 8,
    parameter int PIX_PER_WORD = 16,
    parameter int NUM_WORDS    = 4,
    parameter int BIN_W        = 16,
    parameter int ADDR_W       = 16
) (
    input  logic                            clock,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [PIX_PER_WORD*PIXEL_W-1:0] m1ReadVal,
    input  logic [BIN_W-1:0]                m2ReadVal,
    output logic [ADDR_W-1:0]               m1ReadAddr,
    output logic [PIXEL_W-1:0]              m2ReadAddr,
    output logic [PIXEL_W-1:0]              m2WriteAddr,
    output logic [BIN_W-1:0]                m2WriteVal,
    output logic                            m2WE,
    output logic                            busy,
    output logic                            done
);

    localparam int LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam logic [PIXEL_W-1:0] LAST_BIN  = '1;
    localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(PIX_PER_WORD - 1);
    localparam logic [ADDR_W-1:0]  LAST_WORD = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_COUNT, S_DRAIN, S_DONE} state_t;

    state_t              state, state_nx;
    logic [PIXEL_W-1:0]  clr_cnt;
    logic [LANE_W-1:0]   lane_cnt;
    logic [ADDR_W-1:0]   word_cnt;
    logic [1:0]          drain_cnt;
    logic                start_ok;
    logic [PIXEL_W-1:0]  pixel;

    logic                r_valid, a_valid, w_valid;
    logic [PIXEL_W-1:0]  r_bin, a_bin, w_bin;
    logic [BIN_W-1:0]    a_cnt, w_val, r_sel, a_inc;

    assign start_ok = start && (state == S_IDLE || state == S_DONE);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = S_CLEAR;
            S_CLEAR:        if (clr_cnt == LAST_BIN) state_nx = S_COUNT;
            S_COUNT:        if (lane_cnt == LAST_LANE && word_cnt == LAST_WORD) state_nx = S_DRAIN;
            S_DRAIN:        if (drain_cnt == 2'd2) state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == S_CLEAR) || (state == S_COUNT) || (state == S_DRAIN);
        done        = (state == S_DONE);
        m2WE        = (state == S_CLEAR) || w_valid;
        m2WriteAddr = (state == S_CLEAR) ? clr_cnt : w_bin;
        m2WriteVal  = (state == S_CLEAR) ? '0 : w_val;
        m2ReadAddr  = (state == S_COUNT) ? pixel : '0;
        // Next word is fetched during the last lane so its data lands on lane 0.
        if (state == S_COUNT && lane_cnt == LAST_LANE && word_cnt != LAST_WORD)
            m1ReadAddr = word_cnt + ADDR_W'(1);
        else
            m1ReadAddr = word_cnt;
    end

    always_comb begin
        pixel = '0;
        for (int unsigned i = 0; i < PIX_PER_WORD; i++)
            if (lane_cnt == LANE_W'(i)) pixel = m1ReadVal[i*PIXEL_W +: PIXEL_W];
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt   <= '0;
            lane_cnt  <= '0;
            word_cnt  <= '0;
            drain_cnt <= '0;
        end else if (start_ok) begin
            clr_cnt   <= '0;
            lane_cnt  <= '0;
            word_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_CLEAR: clr_cnt <= clr_cnt + PIXEL_W'(1);
                S_COUNT: begin
                    if (lane_cnt == LAST_LANE) begin
                        lane_cnt <= '0;
                        if (word_cnt != LAST_WORD) word_cnt <= word_cnt + ADDR_W'(1);
                    end else begin
                        lane_cnt <= lane_cnt + LANE_W'(1);
                    end
                end
                S_DRAIN: drain_cnt <= drain_cnt + 2'd1;
                default: ;
            endcase
        end
    end

    // Newest in-flight value for the bin wins: A-stage result, then W-stage data, then memory.
    always_comb begin
        if (a_valid && a_bin == r_bin)      r_sel = a_inc;
        else if (w_valid && w_bin == r_bin) r_sel = w_val;
        else                                r_sel = m2ReadVal;
    end

`ifdef HIST_SATURATE_EN
    assign a_inc = (a_cnt == '1) ? a_cnt : a_cnt + BIN_W'(1);
`else
    assign a_inc = a_cnt + BIN_W'(1);
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            a_valid <= 1'b0;
            w_valid <= 1'b0;
            r_bin   <= '0;
            a_bin   <= '0;
            w_bin   <= '0;
            a_cnt   <= '0;
            w_val   <= '0;
        end else begin
            r_valid <= (state == S_COUNT);
            r_bin   <= pixel;
            a_valid <= r_valid;
            a_bin   <= r_bin;
            a_cnt   <= r_sel;
            w_valid <= a_valid;
            w_bin   <= a_bin;
            w_val   <= a_inc;
        end
    end

endmodule

// File: tb/tb_histogram_count_pipeline.sv
// Randomized self-checking bench: images are counted by a plain array histogram and
// compared against the scratchpad contents the DUT leaves behind.
module tb_histogram_count_pipeline;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // ---------------- DUT A: default parameters ----------------
    logic         start_a = 1'b0;
    logic [127:0] m1rd_a = '0;
    logic [15:0]  m2rd_a = '0;
    logic [15:0]  m1addr_a;
    logic [7:0]   m2ra_a, m2wa_a;
    logic [15:0]  m2wv_a;
    logic         m2we_a, busy_a, done_a;

    histogram_count_pipeline dut_a (
        .clock(clock), .rst_n(rst_n), .start(start_a),
        .m1ReadVal(m1rd_a), .m2ReadVal(m2rd_a),
        .m1ReadAddr(m1addr_a), .m2ReadAddr(m2ra_a), .m2WriteAddr(m2wa_a),
        .m2WriteVal(m2wv_a), .m2WE(m2we_a), .busy(busy_a), .done(done_a)
    );

    logic [127:0] m1a [0:3];
    logic [15:0]  m2a [0:255];
    always @(posedge clock) begin
        m1rd_a <= m1a[m1addr_a[1:0]];
        if (m2we_a) m2a[m2wa_a] <= m2wv_a;
        m2rd_a <= (m2we_a && m2wa_a == m2ra_a) ? m2wv_a : m2a[m2ra_a];
    end

    // ---------------- DUT B: 4-bit pixels and bins ----------------
    logic        start_b = 1'b0;
    logic [15:0] m1rd_b = '0;
    logic [3:0]  m2rd_b = '0;
    logic [15:0] m1addr_b;
    logic [3:0]  m2ra_b, m2wa_b, m2wv_b;
    logic        m2we_b, busy_b, done_b;

    histogram_count_pipeline #(
        .PIXEL_W(4), .PIX_PER_WORD(4), .NUM_WORDS(5), .BIN_W(4), .ADDR_W(16)
    ) dut_b (
        .clock(clock), .rst_n(rst_n), .start(start_b),
        .m1ReadVal(m1rd_b), .m2ReadVal(m2rd_b),
        .m1ReadAddr(m1addr_b), .m2ReadAddr(m2ra_b), .m2WriteAddr(m2wa_b),
        .m2WriteVal(m2wv_b), .m2WE(m2we_b), .busy(busy_b), .done(done_b)
    );

    logic [15:0] m1b [0:7];
    logic [3:0]  m2b [0:15];
    always @(posedge clock) begin
        m1rd_b <= m1b[m1addr_b[2:0]];
        if (m2we_b) m2b[m2wa_b] <= m2wv_b;
        m2rd_b <= (m2we_b && m2wa_b == m2ra_b) ? m2wv_b : m2b[m2ra_b];
    end

    // ---------------- monitors ----------------
    int wr_a = 0, wr_b = 0, we_idle = 0;
    always @(negedge clock) begin
        if (m2we_a) wr_a++;
        if (m2we_b) wr_b++;
        if ((m2we_a && !busy_a) || (m2we_b && !busy_b)) we_idle++;
    end

    // ---------------- reference model ----------------
    int pix [64];
    int exp_a [256];

    task automatic load_a();
        for (int b = 0; b < 256; b++) exp_a[b] = 0;
        for (int i = 0; i < 64; i++) begin
            exp_a[pix[i]] = (exp_a[pix[i]] + 1) % 65536;
            m1a[i / 16][(i % 16) * 8 +: 8] = 8'(pix[i]);
        end
    endtask

    task automatic check_bins_a(input string name);
        for (int b = 0; b < 256; b++)
            expect_eq($sformatf("%s_bin%0d", name, b), 64'(m2a[b]), 64'(exp_a[b]));
    endtask

    task automatic run_a(input string name, input int glitch_at);
        int n;
        @(posedge clock); #1;
        wr_a = 0;
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        n = 1;
        expect_eq({name, "_done_drop"}, 64'(done_a), 64'd0);
        expect_eq({name, "_busy"}, 64'(busy_a), 64'd1);
        expect_eq({name, "_first_clr"}, {55'd0, m2we_a, m2wa_a}, {55'd0, 1'b1, 8'd0});
        while (!done_a && n < 2000) begin
            if (n == glitch_at) start_a = 1'b1;
            @(posedge clock); #1;
            start_a = 1'b0;
            n++;
        end
        expect_eq({name, "_latency"}, 64'(n), 64'd324);
        expect_eq({name, "_writes"}, 64'(wr_a), 64'd320);
        check_bins_a(name);
    endtask

    task automatic check_reset_outputs(input string name);
        expect_eq({name, "_rst_outs"},
                  {m1addr_a, m2ra_a, m2wa_a, m2wv_a, m2we_a, busy_a, done_a},
                  '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2;
        check_reset_outputs("reset");
        expect_eq("reset_b", {m2we_b, busy_b, done_b}, 64'd0);
        #10 rst_n = 1'b1;

        for (int i = 0; i < 64; i++) pix[i] = i;
        load_a();
        run_a("ramp", 0);

        for (int i = 0; i < 64; i++) pix[i] = 'h5A;
        load_a();
        run_a("same", 0);

        for (int i = 0; i < 64; i++) pix[i] = (i % 2 == 0) ? 'h10 : 'h20;
        load_a();
        run_a("alt", 0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 64; i++)
                pix[i] = (r < 2) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
            load_a();
            run_a($sformatf("rand%0d", r), 0);
        end

        for (int i = 0; i < 64; i++) pix[i] = int'($urandom_range(0, 7)) * 3;
        load_a();
        run_a("glitch", 300);

        // reset while counting, then a clean recount
        @(posedge clock); #1;
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        n = 1;
        while (n < 280) begin
            @(posedge clock); #1;
            n++;
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            expect_eq($sformatf("midrst_we%0d", k), {m2we_a, busy_a}, 64'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) pix[i] = int'($urandom_range(0, 255));
        load_a();
        run_a("after_rst", 0);

        // DUT B: 20 hits on bin 3 with 4-bit counts
        for (int w = 0; w < 8; w++) m1b[w] = 16'h3333;
        @(posedge clock); #1;
        wr_b = 0;
        start_b = 1'b1;
        @(posedge clock); #1;
        start_b = 1'b0;
        n = 1;
        while (!done_b && n < 500) begin
            @(posedge clock); #1;
            n++;
        end
        expect_eq("b_latency", 64'(n), 64'd40);
        expect_eq("b_writes", 64'(wr_b), 64'd36);
`ifdef HIST_SATURATE_EN
        expect_eq("b_bin3", 64'(m2b[3]), 64'd15);
`else
        expect_eq("b_bin3", 64'(m2b[3]), 64'(20 % 16));
`endif
        for (int b = 0; b < 16; b++)
            if (b != 3) expect_eq($sformatf("b_bin%0d", b), 64'(m2b[b]), 64'd0);

        repeat (3) @(posedge clock);
        #1 expect_eq("we_idle", 64'(we_idle), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
